// File: rtl/fetch_unit.sv
// Jac1-8 instruction fetch stage: owns the PC, fetches 16-bit words over req/ack,
// and resolves sequential / absolute / relative next-PC. Optional macro: FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int                  PC_WIDTH          = 8,
    parameter int                  PROGRAM_DataWidth = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR      = '0,
    parameter int                  TIMEOUT_CYCLES    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    output logic [PC_WIDTH-1:0]          mem_addr,
    output logic                         mem_req,
    input  logic                         mem_ack,
    input  logic [PROGRAM_DataWidth-1:0] mem_data,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    input  logic                         cnt_wr_en,
    input  logic                         add_offset,
    input  logic [7:0]                   literal_adr,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, EXEC} state_e;

    state_e                         state_q;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic [PROGRAM_DataWidth-1:0]   ir_q;
    logic                           instr_valid_q;
    logic                           mem_req_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          fetch_err_q;
    assign fetch_err = fetch_err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign fetch_err  = 1'b0;
`endif

    // Relative offsets are signed and taken from this instruction's own address.
    always_comb begin
        pc_d = pc_q + PC_WIDTH'(1);
        if (cnt_wr_en && add_offset)
            pc_d = pc_q + PC_WIDTH'($signed(literal_adr));
        else if (cnt_wr_en)
            pc_d = PC_WIDTH'(literal_adr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            ir_q          <= '0;
            instr_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q         <= '0;
            fetch_err_q   <= 1'b0;
`endif
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run && !fetch_err) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end
                REQ, WAIT: begin
                    if (mem_ack) begin
                        ir_q          <= mem_data;
                        state_q       <= EXEC;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (state_q == WAIT && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        fetch_err_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        if (state_q == WAIT)
                            tmo_q <= tmo_q + TW'(1);
                    end
`else
                    else begin
                        state_q <= WAIT;
                    end
`endif
                end
                EXEC: begin
                    pc_q <= pc_d;
                    // A dropped run lets this instruction retire, then idles.
                    if (run) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign mem_req     = mem_req_q;
    assign instruction = ir_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level PC/IR model with randomized
// memory latency, decoder controls and instruction data.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, run, mem_ack, cnt_wr_en, add_offset;
    logic [7:0]  literal_adr, mem_addr, pc;
    logic [15:0] mem_data, instruction;
    logic        mem_req, instr_valid, fetch_err;

    int          errs = 0;
    int          checks = 0;
    logic [7:0]  exp_pc;
    logic [15:0] exp_ir;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
        .instruction(instruction), .instr_valid(instr_valid),
        .cnt_wr_en(cnt_wr_en), .add_offset(add_offset), .literal_adr(literal_adr),
        .pc(pc), .fetch_err(fetch_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One complete fetch: wait for the request, hold off ack for 'delay' cycles,
    // deliver 'data', drive decoder controls in EXEC and check the next PC.
    task automatic run_instr(input int delay, input logic cwe, input logic ao,
                             input logic [7:0] lit, input logic [15:0] data,
                             input logic run_after, input logic drop_in_wait);
        int n = 0;
        while (mem_req !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errs++;
            $display("FAIL req_start mem_req=%b required 1", mem_req);
        end
        for (int i = 0; i < delay; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_pc || instr_valid !== 1'b0 || instruction !== exp_ir) begin
                errs++;
                $display("FAIL wait_hold cyc=%0d req=%b addr=%h iv=%b ir=%h required req=1 addr=%h iv=0 ir=%h",
                         i, mem_req, mem_addr, instr_valid, instruction, exp_pc, exp_ir);
            end
            mem_ack  = 1'b0;
            mem_data = 16'($urandom);
            if (drop_in_wait) run = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin
            errs++;
            $display("FAIL ack_cycle req=%b addr=%h required req=1 addr=%h", mem_req, mem_addr, exp_pc);
        end
        mem_ack  = 1'b1;
        mem_data = data;
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = 16'($urandom);
        checks++;
        if (instr_valid !== 1'b1 || instruction !== data || pc !== exp_pc || mem_req !== 1'b0) begin
            errs++;
            $display("FAIL exec iv=%b ir=%h pc=%h req=%b required iv=1 ir=%h pc=%h req=0",
                     instr_valid, instruction, pc, mem_req, data, exp_pc);
        end
        exp_ir      = data;
        cnt_wr_en   = cwe;
        add_offset  = ao;
        literal_adr = lit;
        run         = run_after;
        if (cwe && ao)  exp_pc = 8'(int'(exp_pc) + int'($signed(lit)));
        else if (cwe)   exp_pc = lit;
        else            exp_pc = 8'(int'(exp_pc) + 1);
        @(negedge clk);
        cnt_wr_en   = 1'($urandom);
        add_offset  = 1'($urandom);
        literal_adr = 8'($urandom);
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== run_after || pc !== exp_pc || fetch_err !== 1'b0) begin
            errs++;
            $display("FAIL after_exec iv=%b req=%b pc=%h err=%b required iv=0 req=%b pc=%h err=0",
                     instr_valid, mem_req, pc, fetch_err, run_after, exp_pc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_data = '0;
        cnt_wr_en = 1'b0; add_offset = 1'b0; literal_adr = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctrl req=%b iv=%b err=%b required 0 0 0", mem_req, instr_valid, fetch_err);
        end
        checks++;
        if (pc !== 8'h00 || mem_addr !== 8'h00 || instruction !== 16'h0000) begin
            errs++;
            $display("FAIL reset_regs pc=%h addr=%h ir=%h required 00 00 0000", pc, mem_addr, instruction);
        end
        exp_pc = 8'h00;
        exp_ir = 16'h0000;
        rst_n  = 1'b1;
    endtask

    task automatic test_sequential();
        run = 1'b1;
        for (int i = 0; i < 256; i++) run_instr(0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (pc !== 8'h00) begin
            errs++;
            $display("FAIL pc_wrap pc=%h required 00", pc);
        end
        for (int i = 0; i < 5; i++) run_instr(0, 1'b0, 1'b0, 8'h00, 16'($urandom), 1'b1, 1'b0);
        checks++;
        if (pc !== 8'h05) begin
            errs++;
            $display("FAIL seq_pc pc=%h required 05", pc);
        end
    endtask

    task automatic test_jumps();
        run_instr(0, 1'b1, 1'b0, 8'h40, 16'hA040, 1'b1, 1'b0);
        checks++;
        if (mem_addr !== 8'h40) begin
            errs++;
            $display("FAIL goto addr=%h required 40", mem_addr);
        end
        run_instr(0, 1'b1, 1'b0, 8'h10, 16'hA010, 1'b1, 1'b0);
        run_instr(0, 1'b1, 1'b1, 8'hFE, 16'hB0FE, 1'b1, 1'b0);
        checks++;
        if (pc !== 8'h0E) begin
            errs++;
            $display("FAIL rel_back pc=%h required 0E", pc);
        end
        run_instr(0, 1'b1, 1'b0, 8'h10, 16'hA010, 1'b1, 1'b0);
        run_instr(0, 1'b1, 1'b1, 8'h00, 16'hB000, 1'b1, 1'b0);
        checks++;
        if (pc !== 8'h10) begin
            errs++;
            $display("FAIL self_loop pc=%h required 10", pc);
        end
        run_instr(1, 1'b1, 1'b0, 8'h02, 16'hA002, 1'b1, 1'b0);
        run_instr(0, 1'b1, 1'b1, 8'hFC, 16'hB0FC, 1'b1, 1'b0);
        checks++;
        if (pc !== 8'hFE) begin
            errs++;
            $display("FAIL rel_wrap pc=%h required FE", pc);
        end
    endtask

    task automatic test_mem_delay();
        for (int d = 1; d <= 4; d++) run_instr(d, 1'b0, 1'b0, 8'h00, 16'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_run_drop();
        run_instr(2, 1'b0, 1'b0, 8'h00, 16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_ack  = 1'b1;
            mem_data = 16'hDEAD;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 16'h1234 || pc !== exp_pc) begin
                errs++;
                $display("FAIL idle_hold req=%b iv=%b ir=%h pc=%h required 0 0 1234 %h",
                         mem_req, instr_valid, instruction, pc, exp_pc);
            end
        end
        mem_ack = 1'b0;
        run     = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            run = 1'b1;
            run_instr(int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 8'($urandom),
                      16'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end
        run = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        run = 1'b1;
        mem_ack = 1'b0;
        while (mem_req !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 8'h00 || instr_valid !== 1'b0 || instruction !== 16'h0000) begin
            errs++;
            $display("FAIL async_reset req=%b pc=%h iv=%b ir=%h required 0 00 0 0000",
                     mem_req, pc, instr_valid, instruction);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 8'h00;
        exp_ir = 16'h0000;
        run_instr(0, 1'b0, 1'b0, 8'h00, 16'h5555, 1'b1, 1'b0);
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        int hi = 0;
        run = 1'b1;
        mem_ack = 1'b0;
        while (mem_req !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        while (mem_req === 1'b1 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== 17 || fetch_err !== 1'b1) begin
            errs++;
            $display("FAIL timeout req_cycles=%0d err=%b required 17 1", hi, fetch_err);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || fetch_err !== 1'b1 || pc !== exp_pc) begin
                errs++;
                $display("FAIL err_idle req=%b err=%b pc=%h required 0 1 %h", mem_req, fetch_err, pc, exp_pc);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (fetch_err !== 1'b0) begin
            errs++;
            $display("FAIL err_clear err=%b required 0", fetch_err);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 8'h00;
        exp_ir = 16'h0000;
        run_instr(0, 1'b0, 1'b0, 8'h00, 16'h7777, 1'b1, 1'b0);
    endtask
`else
    task automatic test_timeout();
        int n = 0;
        run = 1'b1;
        mem_ack = 1'b0;
        while (mem_req !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 40; i++) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || fetch_err !== 1'b0 || mem_addr !== exp_pc) begin
            errs++;
            $display("FAIL long_wait req=%b err=%b addr=%h required 1 0 %h", mem_req, fetch_err, mem_addr, exp_pc);
        end
        run_instr(0, 1'b0, 1'b0, 8'h00, 16'h7777, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_jumps();
        test_mem_delay();
        test_run_drop();
        test_random();
        test_reset_mid_wait();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder in the Jac1-8 8-bit core.
- Owns the program counter (PC) and requests 16-bit instruction words from program memory over a req/ack handshake.
- Latches each word into the instruction register (IR) that drives the decoder's instruction input, and asserts instr_valid for one execute cycle.
- Consumes the decoder's cnt_wr_en, add_offset and literal_adr to compute the next PC: sequential, absolute jump, or relative branch.

Parameters:
- PC_WIDTH, 8, width of PC and program memory address.
- PROGRAM_DataWidth, 16, instruction word width.
- RESET_VECTOR, 8'h00, PC value after reset.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before a fetch error; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  core enable; level-sensitive.
- mem_addr  out  PC_WIDTH  program memory address; equals pc.
- mem_req  out  1  fetch request.
- mem_ack  in  1  memory has mem_data valid this cycle.
- mem_data  in  PROGRAM_DataWidth  instruction word from memory.
- instruction  out  PROGRAM_DataWidth  IR contents; goes to the decoder.
- instr_valid  out  1  high only in the EXEC cycle; qualifies the decoder's wr_en, stat_wr_en and cnt_wr_en.
- cnt_wr_en  in  1  from decoder: load the PC instead of incrementing.
- add_offset  in  1  from decoder: with cnt_wr_en, the PC load is relative.
- literal_adr  in  8  from decoder: absolute target or signed offset.
- pc  out  PC_WIDTH  current PC, i.e. the address of the instruction in IR.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, takes effect immediately in any state, including mid-WAIT):
  - state=IDLE, pc=RESET_VECTOR, IR=16'h0000 (NOP).
  - instr_valid=0, mem_req=0, fetch_err=0.
- FSM states: IDLE, REQ, WAIT, EXEC. All outputs are registered except mem_addr=pc.
- IDLE: mem_req=0. If run=1, go to REQ next cycle.
- REQ: mem_req=1.
  - If mem_ack=1 in the same cycle: IR<=mem_data, go to EXEC.
  - Otherwise go to WAIT.
- WAIT: mem_req held at 1, mem_addr held stable.
  - On the first cycle with mem_ack=1: IR<=mem_data, go to EXEC.
  - mem_ack while mem_req=0 is ignored.
- EXEC: exactly one cycle, instr_valid=1, mem_req=0; the decoder evaluates IR combinationally. At the end of the cycle, PC update by priority:
  - cnt_wr_en=1 and add_offset=1: pc <= pc + sign_extend(literal_adr). Offset is relative to this instruction's address; offset 0 gives a self-loop.
  - cnt_wr_en=1 and add_offset=0: pc <= literal_adr (zero-extended to PC_WIDTH).
  - otherwise: pc <= pc + 1.
  - All PC arithmetic is modulo 2^PC_WIDTH: 8'hFF+1 gives 8'h00, and 8'h02 + 8'hFC gives 8'hFE.
- After EXEC: if run=1, go to REQ; otherwise go to IDLE.
  - Deasserting run never aborts a fetch in progress: the current instruction completes EXEC, then the block idles.
- IR holds its value outside EXEC. Consumers must gate on instr_valid.
- Minimum throughput: 2 cycles per instruction (REQ with immediate ack, then EXEC).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mem_ack, then next cycle: mem_req=0, fetch_err=1 (sticky until reset), state=IDLE, pc unchanged.
  - While fetch_err=1 the FSM stays in IDLE regardless of run.
- Undefined: no counter; WAIT may last indefinitely; fetch_err is tied to 0.

Test Plan:
- Reset, run=1, memory acks in the same cycle, ROM holds NOPs → mem_addr sequence 00,01,02…; instr_valid pulses every 2nd cycle; pc wraps FF→00.
- GOTO at 8'h05 decoded to cnt_wr_en=1, add_offset=0, literal=8'h40 → next mem_addr=8'h40.
- IFZ at 8'h10 decoded to cnt_wr_en=1, add_offset=1, literal=8'hFE → next pc=8'h0E. With literal=8'h00 → pc stays 8'h10.
- mem_ack delayed 3 cycles → mem_req high for 4 cycles with stable mem_addr; IR updates only on the ack cycle; instr_valid=1 for exactly one cycle.
- run dropped during WAIT → the fetch completes, EXEC occurs, then IDLE with mem_req=0. rst_n pulsed low mid-WAIT → mem_req=0 immediately and pc=RESET_VECTOR.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ack never asserted → fetch_err=1 after 16 WAIT cycles, mem_req=0, the FSM stays in IDLE while run=1, and the flag is cleared only by rst_n.
